// File: rtl/vga_timing.sv
// vga_timing: 640x480 raster timing generator.
// Pixel strobe, position counters and registered sync/valid decode.
module vga_timing #(
  parameter int CLK_DIV  = 4,
  parameter int H_DISP   = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_DISP   = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_en,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       valid,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start
);

  localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  // 11-bit bounds so an end value of 1024 still compares correctly
  localparam logic [10:0] H_ACT = 11'(H_DISP);
  localparam logic [10:0] HS_B  = 11'(H_DISP + H_FP);
  localparam logic [10:0] HS_E  = 11'(H_DISP + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT = 11'(V_DISP);
  localparam logic [10:0] VS_B  = 11'(V_DISP + V_FP);
  localparam logic [10:0] VS_E  = 11'(V_DISP + V_FP + V_SYNC);

  logic [DW-1:0] div_cnt;
  logic          h_last;
  logic          v_last;
  logic [9:0]    h_nxt;
  logic [9:0]    v_nxt;
  logic [10:0]   hx;
  logic [10:0]   vx;

  generate
    if (CLK_DIV > 1) begin : g_div
      // free-running divider, wraps after CLK_DIV-1
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          div_cnt <= '0;
        else if (div_cnt == DIV_LAST)
          div_cnt <= '0;
        else
          div_cnt <= div_cnt + 1'b1;
      end
    end else begin : g_nodiv
      assign div_cnt = '0;
    end
  endgenerate

  assign pix_en = (div_cnt == DIV_LAST);

  // position the counters will take on the next pixel strobe
  always_comb begin
    h_last = (h_cnt == H_LAST);
    v_last = (v_cnt == V_LAST);
    h_nxt  = h_last ? 10'd0 : h_cnt + 10'd1;
    v_nxt  = v_cnt;
    if (h_last)
      v_nxt = v_last ? 10'd0 : v_cnt + 10'd1;
    hx = {1'b0, h_nxt};
    vx = {1'b0, v_nxt};
  end

  // raster position advances once per pixel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
    end
  end

  // decode from the next position so outputs line up with h_cnt/v_cnt
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid       <= 1'b1;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_en && h_last && v_last;
      if (pix_en) begin
        valid <= (hx < H_ACT) && (vx < V_ACT);
        hsync <= (hx >= HS_B && hx < HS_E) ? SYNC_POL : ~SYNC_POL;
        vsync <= (vx >= VS_B && vx < VS_E) ? SYNC_POL : ~SYNC_POL;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: default, CLK_DIV=1/active-high and a shrunken raster
// checked each cycle against an arithmetic position model.
module tb_vga_timing;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic chk = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  int   t = 0;

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst)
    if (rst) t <= 0;
    else t <= t + 1;

  logic       pe_a, va_a, hs_a, vs_a, fs_a;
  logic [9:0] h_a, v_a;
  logic       pe_b, va_b, hs_b, vs_b, fs_b;
  logic [9:0] h_b, v_b;
  logic       pe_c, va_c, hs_c, vs_c, fs_c;
  logic [9:0] h_c, v_c;

  vga_timing dut_a (
    .clk(clk), .rst(rst), .pix_en(pe_a), .h_cnt(h_a), .v_cnt(v_a),
    .valid(va_a), .hsync(hs_a), .vsync(vs_a), .frame_start(fs_a));

  vga_timing #(.CLK_DIV(1), .SYNC_POL(1'b1)) dut_b (
    .clk(clk), .rst(rst), .pix_en(pe_b), .h_cnt(h_b), .v_cnt(v_b),
    .valid(va_b), .hsync(hs_b), .vsync(vs_b), .frame_start(fs_b));

  vga_timing #(
    .CLK_DIV(2), .H_DISP(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_DISP(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0)
  ) dut_c (
    .clk(clk), .rst(rst), .pix_en(pe_c), .h_cnt(h_c), .v_cnt(v_c),
    .valid(va_c), .hsync(hs_c), .vsync(vs_c), .frame_start(fs_c));

  task automatic cmp(input string nm, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: wait bound expired, got none, expected event", nm);
  endtask

  // position = number of strobes since reset, folded into the raster
  task automatic model(
    input string nm, input int d,
    input int hd, input int hf, input int hs, input int hb,
    input int vd, input int vf, input int vs, input int vb,
    input bit pol, input int tt,
    input logic pe, input logic [9:0] h, input logic [9:0] v,
    input logic va, input logic hy, input logic vy, input logic fs);
    int ht, vt, n, p, eh, ev;
    logic epe, efs, eva, ehs, evs;
    ht  = hd + hf + hs + hb;
    vt  = vd + vf + vs + vb;
    n   = tt / d;
    p   = n % (ht * vt);
    eh  = p % ht;
    ev  = p / ht;
    epe = (tt % d) == d - 1;
    efs = (n > 0) && (p == 0) && (tt % d == 0);
    eva = (eh < hd) && (ev < vd);
    ehs = (eh >= hd + hf && eh < hd + hf + hs) ? pol : !pol;
    evs = (ev >= vd + vf && ev < vd + vf + vs) ? pol : !pol;
    n_vec++;
    if (pe !== epe || int'(h) != eh || int'(v) != ev || va !== eva ||
        hy !== ehs || vy !== evs || fs !== efs) begin
      n_err++;
      $display("FAIL %s t=%0d got pe%b h%0d v%0d va%b hs%b vs%b fs%b expected pe%b h%0d v%0d va%b hs%b vs%b fs%b",
               nm, tt, pe, h, v, va, hy, vy, fs,
               epe, eh, ev, eva, ehs, evs, efs);
    end
  endtask

  always @(negedge clk) begin
    if (chk) begin
      model("dflt", 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, t,
            pe_a, h_a, v_a, va_a, hs_a, vs_a, fs_a);
      model("div1", 1, 640, 16, 96, 48, 480, 10, 2, 33, 1'b1, t,
            pe_b, h_b, v_b, va_b, hs_b, vs_b, fs_b);
      model("small", 2, 8, 2, 3, 2, 4, 1, 2, 1, 1'b0, t,
            pe_c, h_c, v_c, va_c, hs_c, vs_c, fs_c);
    end
  end

  initial begin
    int k, hs_lo, va_hi, t0;
    bit hit;
    logic prev;

    repeat (3) @(posedge clk);
    #1;
    cmp("rst_h", h_a, 0);
    cmp("rst_v", v_a, 0);
    cmp("rst_valid", va_a, 1);
    cmp("rst_hsync", hs_a, 1);
    cmp("rst_vsync", vs_a, 1);
    cmp("rst_fs", fs_a, 0);
    cmp("rst_pe", pe_a, 0);
    cmp("rst_pe_div1", pe_b, 1);
    cmp("rst_hsync_pol1", hs_b, 0);
    @(negedge clk);
    rst = 1'b0;
    chk = 1'b1;

    for (int s = 1; s <= 3; s++) begin
      repeat (3) @(posedge clk);
      #1;
      cmp("strobe_pe", pe_a, 1);
      @(posedge clk);
      #1;
      cmp("strobe_h", h_a, s);
      cmp("strobe_pe_low", pe_a, 0);
    end

    hit = 0;
    for (k = 0; k < 20000 && !hit; k++) begin
      @(negedge clk);
      if (h_a == 10'd300 && v_a == 10'd2) hit = 1;
    end
    if (!hit) timeout("reach_300_2");
    #2;
    rst = 1'b1;
    #1;
    cmp("async_h", h_a, 0);
    cmp("async_v", v_a, 0);
    cmp("async_valid", va_a, 1);
    cmp("async_hsync", hs_a, 1);
    cmp("async_vsync", vs_a, 1);
    cmp("async_fs", fs_a, 0);
    cmp("async_pe", pe_a, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;

    hs_lo = 0;
    va_hi = 0;
    for (int i = 0; i < 3200; i++) begin
      if (hs_a == 1'b0) hs_lo++;
      if (va_a == 1'b1) va_hi++;
      @(negedge clk);
      #1;
    end
    cmp("hsync_low_clks", hs_lo, 384);
    cmp("valid_clks_line0", va_hi, 2560);

    hit = 0;
    for (k = 0; k < 50000 && !hit; k++) begin
      @(negedge clk);
      if (h_a == 10'd799 && v_a == 10'd10 && pe_a) hit = 1;
    end
    if (!hit) timeout("reach_799_10");
    @(posedge clk);
    #1;
    cmp("wrap_h", h_a, 0);
    cmp("wrap_v", v_a, 11);
    cmp("wrap_valid", va_a, 1);
    cmp("wrap_fs", fs_a, 0);

    hit = 0;
    for (k = 0; k < 2000 && !hit; k++) begin
      @(negedge clk);
      if (h_b == 10'd700) hit = 1;
    end
    if (!hit) timeout("div1_h700");
    cmp("div1_hsync_high", hs_b, 1);
    cmp("div1_pe", pe_b, 1);
    hit = 0;
    for (k = 0; k < 2000 && !hit; k++) begin
      @(negedge clk);
      if (h_b == 10'd0) hit = 1;
    end
    if (!hit) timeout("div1_h0");
    t0 = t;
    hit = 0;
    for (k = 0; k < 2000 && !hit; k++) begin
      @(negedge clk);
      if (h_b == 10'd0) hit = 1;
    end
    if (!hit) timeout("div1_h0_next");
    cmp("div1_line_clks", t - t0, 800);

    hit = 0;
    prev = vs_c;
    for (k = 0; k < 1000 && !hit; k++) begin
      @(negedge clk);
      if (prev && !vs_c) hit = 1;
      prev = vs_c;
    end
    if (!hit) timeout("small_vsync_fall");
    t0 = t;
    hit = 0;
    for (k = 0; k < 1000 && !hit; k++) begin
      @(negedge clk);
      if (prev && !vs_c) hit = 1;
      prev = vs_c;
    end
    if (!hit) timeout("small_vsync_fall2");
    cmp("small_vsync_period", t - t0, 240);
    cmp("small_vsync_line", v_c, 5);

    hit = 0;
    for (k = 0; k < 1000 && !hit; k++) begin
      @(negedge clk);
      if (fs_c) hit = 1;
    end
    if (!hit) timeout("small_fs");
    cmp("small_fs_h", h_c, 0);
    cmp("small_fs_v", v_c, 0);
    @(negedge clk);
    cmp("small_fs_width", fs_c, 0);

    chk = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
# vga_timing

Raster timing generator for the dino game's 640x480@60 Hz VGA output. It divides the system clock down to a pixel-enable strobe and runs the horizontal and vertical position counters. It drives the `hsync`/`vsync` pins and the `h_cnt`/`v_cnt`/`valid` position bus. That bus is the driving end of the interface consumed by the sprite renderers (cactus, dino, ground, score), and its `vsync` is the per-frame tick those renderers use for motion.

## Interface

Parameters:
- `CLK_DIV`, 4: system clocks per pixel. Must be ≥1; 100 MHz / 4 = 25 MHz pixel rate.
- `H_DISP`, 640: active pixels per line.
- `H_FP`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: horizontal sync width, in pixels.
- `H_BP`, 48: horizontal back porch, in pixels. H_TOTAL = 800.
- `V_DISP`, 480: active lines per frame.
- `V_FP`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vertical sync width, in lines.
- `V_BP`, 33: vertical back porch, in lines. V_TOTAL = 525.
- `SYNC_POL`, 0: level driven on `hsync`/`vsync` while asserted (0 = active-low).

Ports:
- `clk` in 1: system clock; all state changes on its rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `pix_en` out 1: one-`clk` pixel strobe.
- `h_cnt` out 10: horizontal position, 0..H_TOTAL-1, raw (not gated by `valid`).
- `v_cnt` out 10: vertical position, 0..V_TOTAL-1, raw.
- `valid` out 1: current position is inside the active region.
- `hsync` out 1: horizontal sync to the VGA connector.
- `vsync` out 1: vertical sync to the VGA connector and the renderers.
- `frame_start` out 1: one-`clk` pulse when the position becomes (0,0).

## Operation

Pixel divider:
- `div_cnt` counts 0..CLK_DIV-1 on every `clk` and wraps to 0.
- `pix_en` = (`div_cnt` == CLK_DIV-1).
- With CLK_DIV=1, `pix_en` is constantly 1 and `div_cnt` is constant 0.

Position counters (both advance only on edges where `pix_en`=1):
- `h_cnt` increments; at H_TOTAL-1 it wraps to 0.
- `v_cnt` increments only on the same edge as the `h_cnt` wrap; at V_TOTAL-1 it wraps to 0.
- Both counters are 10 bits. H_TOTAL and V_TOTAL must be ≤1024, and no out-of-range value is ever reached.

Decode. Outputs are registered and always correspond to the current `h_cnt`/`v_cnt`; there is no skew between the position and the sync/valid outputs.
- `valid` = (`h_cnt` < H_DISP) && (`v_cnt` < V_DISP).
- `hsync` = SYNC_POL when H_DISP+H_FP ≤ `h_cnt` < H_DISP+H_FP+H_SYNC (656..751 at default); otherwise ~SYNC_POL.
- `vsync` = SYNC_POL when V_DISP+V_FP ≤ `v_cnt` < V_DISP+V_FP+V_SYNC (490..491 at default); otherwise ~SYNC_POL.
- `frame_start` is 1 for exactly the one `clk` cycle immediately after the edge on which both counters wrap to (0,0). It is 0 at all other times, including after reset.

Reset (asynchronous, takes effect immediately regardless of `clk`):
- `div_cnt`=0, `h_cnt`=0, `v_cnt`=0.
- `valid`=1, `hsync`=`vsync`=~SYNC_POL, `frame_start`=0.
- `pix_en`=0 when CLK_DIV>1 (1 when CLK_DIV=1).
- Reset mid-line or mid-frame discards the position; counting restarts from (0,0) with no partial-frame `frame_start`.

## Timing

- First `pix_en` occurs in the cycle where `div_cnt`=CLK_DIV-1, i.e. on the 4th rising edge after `rst` deasserts at default settings. `h_cnt` becomes 1 on that edge.
- One pixel = CLK_DIV clk cycles.
- One line = H_TOTAL×CLK_DIV = 3200 clk.
- One frame = V_TOTAL lines = 1,680,000 clk (16.8 ms at 100 MHz).
- `hsync` asserted width = H_SYNC×CLK_DIV = 384 clk.
- `vsync` asserted width = V_SYNC lines = 6400 clk.
- Line wrap: `h_cnt` 799→0 and `v_cnt` +1 change on the same edge.
- Frame wrap: `h_cnt` 799→0 and `v_cnt` 524→0 change on the same edge, and `frame_start` rises on that edge.
- Position, `valid`, `hsync` and `vsync` all change only on `pix_en` edges; they are stable for CLK_DIV cycles between changes.

## Test plan

- Reset: assert `rst` asynchronously mid-frame (e.g. at `h_cnt`=300, `v_cnt`=200). Required: all outputs take their reset values immediately, without a `clk` edge. After release, `pix_en` pulses every 4th clk and `h_cnt` = 1, 2, 3 on successive strobes.
- Horizontal sync: sample one full line. Required: `hsync`=0 for `h_cnt`=656..751 (384 clk), 1 elsewhere; `valid`=1 only for `h_cnt`=0..639 while `v_cnt`<480.
- Line wrap: position (799, 10) plus one `pix_en`. Required: (0, 11) on that edge, `valid`=1, `frame_start`=0.
- Frame wrap: run past (799, 524). Required: (0,0) on that edge with `frame_start`=1 for exactly one clk. `vsync`=0 only for `v_cnt`=490..491, and the `vsync` falling-edge-to-falling-edge period is 1,680,000 clk.
- Configuration: CLK_DIV=1, SYNC_POL=1. Required: `pix_en` constantly 1, `h_cnt` advances every clk, `hsync`/`vsync` active-high, and the line is 800 clk.
